// File: rtl/nibble_serial_alu_ctrl.sv
// rtl/nibble_serial_alu_ctrl.sv - wide add/subtract sequenced one nibble per clock through a single 4-bit adder
// Operands are latched on start; the carry is registered between nibbles and the result is flagged by a done pulse.

module adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s_out,
   output logic       c_out
);
   logic [4:0] c;

   always_comb begin
      c    = '0;
      c[0] = c_in;
      for (int i = 0; i < 4; i++) begin
         s_out[i] = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign c_out = c[4];
endmodule

module nibble_serial_alu_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   c_out,
   output logic                   overflow
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           sub_q, sub_d, carry_q, carry_d;
   logic           c_out_q, c_out_d, ovf_q, ovf_d;
   logic [3:0]     nib_a, nib_b_raw, nib_b, sum_nib;
   logic           sum_c, last_nib;

   assign last_nib = (idx_q == IW'(NIBBLES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)    state_d = S_RUN;
         S_RUN:   if (last_nib) state_d = S_DONE;
         S_DONE:                state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ready = (state_q == S_IDLE);
      busy  = (state_q == S_RUN);
      done  = (state_q == S_DONE);
   end

   always_comb begin
      nib_a     = '0;
      nib_b_raw = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i)) begin
            nib_a     = a_q[i*4 +: 4];
            nib_b_raw = b_q[i*4 +: 4];
         end
      end
   end

   // Subtract is a + ~b + 1: invert B per nibble, seed the carry with sub
   assign nib_b = nib_b_raw ^ {4{sub_q}};

   adder u_adder (
      .a     (nib_a),
      .b     (nib_b),
      .c_in  (carry_q),
      .s_out (sum_nib),
      .c_out (sum_c)
   );

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               carry_d = sub;
               idx_d   = '0;
            end
         end
         S_RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IW'(i)) result_d[i*4 +: 4] = sum_nib;
            end
            carry_d = sum_c;
            if (last_nib) begin
               c_out_d = sum_c;
               ovf_d   = (nib_a[3] == nib_b[3]) && (sum_nib[3] != nib_a[3]);
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result   = result_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// tb/tb_nibble_serial_alu_ctrl.sv - directed vector bench for nibble_serial_alu_ctrl
// Table of hand-computed add/subtract vectors plus protocol, back-to-back and mid-run reset sequences.

module tb_nibble_serial_alu_ctrl;
   localparam int N = 4;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n, start, sub;
   logic [W-1:0]  a, b;
   logic          ready, busy, done, c_out, overflow;
   logic [W-1:0]  result;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] res;
      logic        c;
      logic        ov;
   } vec_t;

   vec_t vecs [10];

   nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("wait_ready", 32'(ready), 32'd1);
   endtask

   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sv);
      wait_ready();
      a     = av;
      b     = bv;
      sub   = sv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_check(input vec_t v, input string tag);
      int nb = 0;
      issue(v.a, v.b, v.sub);
      while (busy && nb < 20) begin
         nb++;
         @(negedge clk);
      end
      chk({tag, " busy_cycles"}, 32'(nb), 32'd4);
      chk({tag, " done"},        32'(done), 32'd1);
      chk({tag, " result"},      32'(result), 32'(v.res));
      chk({tag, " c_out"},       32'(c_out), 32'(v.c));
      chk({tag, " overflow"},    32'(overflow), 32'(v.ov));
      @(negedge clk);
      chk({tag, " done_single"}, 32'(done), 32'd0);
      chk({tag, " ready_after"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int dc;
      int di [2];
      logic [15:0] dr [2];

      vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vecs[8] = '{16'h0001, 16'h8000, 1'b1, 16'h8001, 1'b0, 1'b1};
      vecs[9] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

      // Reset held with start asserted
      rst_n = 1'b0;
      start = 1'b1;
      sub   = 1'b0;
      a     = 16'h1234;
      b     = 16'h0FFF;
      repeat (2) @(negedge clk);
      chk("rst ready",    32'(ready), 32'd1);
      chk("rst busy",     32'(busy), 32'd0);
      chk("rst done",     32'(done), 32'd0);
      chk("rst result",   32'(result), 32'h0);
      chk("rst c_out",    32'(c_out), 32'd0);
      chk("rst overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("post_rst idle", 32'(ready), 32'd1);
      chk("post_rst busy", 32'(busy), 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_check(vecs[i], $sformatf("vec%0d", i));
      end

      // Start pulses during RUN and DONE are ignored
      issue(16'h1111, 16'h2222, 1'b0);
      a     = 16'hFFFF;
      b     = 16'hFFFF;
      sub   = 1'b1;
      start = 1'b1;
      begin
         int nb = 0;
         while (busy && nb < 20) begin
            nb++;
            @(negedge clk);
         end
         chk("ign busy_cycles", 32'(nb), 32'd4);
      end
      chk("ign done",   32'(done), 32'd1);
      chk("ign result", 32'(result), 32'h3333);
      @(negedge clk);
      start = 1'b0;
      chk("ign idle ready",  32'(ready), 32'd1);
      chk("ign idle result", 32'(result), 32'h3333);
      chk("ign idle done",   32'(done), 32'd0);
      @(negedge clk);
      chk("ign no_queue ready", 32'(ready), 32'd1);
      chk("ign no_queue busy",  32'(busy), 32'd0);

      // Back-to-back at minimum issue spacing
      wait_ready();
      a     = 16'h1234;
      b     = 16'h0FFF;
      sub   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      a   = 16'h8000;
      b   = 16'h0001;
      sub = 1'b1;
      dc  = 0;
      di[0] = -1; di[1] = -1;
      dr[0] = '0; dr[1] = '0;
      for (int i = 0; i < 13; i++) begin
         if (done) begin
            if (dc < 2) begin
               di[dc] = i;
               dr[dc] = result;
            end
            dc++;
         end
         if (i == 6) start = 1'b0;
         @(negedge clk);
      end
      chk("b2b done_count", 32'(dc), 32'd2);
      chk("b2b done0_cycle", 32'(di[0]), 32'd4);
      chk("b2b done1_cycle", 32'(di[1]), 32'd10);
      chk("b2b result0", 32'(dr[0]), 32'h2233);
      chk("b2b result1", 32'(dr[1]), 32'h7FFF);
      chk("b2b c_out1", 32'(c_out), 32'd1);
      chk("b2b overflow1", 32'(overflow), 32'd1);

      // Reset on the second RUN cycle aborts the operation
      issue(16'h1234, 16'h1111, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort ready",    32'(ready), 32'd1);
      chk("abort busy",     32'(busy), 32'd0);
      chk("abort done",     32'(done), 32'd0);
      chk("abort result",   32'(result), 32'h0);
      chk("abort c_out",    32'(c_out), 32'd0);
      chk("abort overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) dc++;
         @(negedge clk);
      end
      chk("abort no_done", 32'(dc), 32'd0);
      run_check(vecs[9], "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
